alu_operand_stage: RTL and testbench

//   Operand-staging pipeline stage directly upstream of the integer ALU.

---
 rtl/alu_operand_stage.sv | 155 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Brief    : 2-entry in-order operand staging FIFO with writeback snooping.
// Revision : 1.0
// ============================================================================
module alu_operand_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic                  in_rs1_rdy,
  input  logic [REG_AW-1:0]     in_rs2,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  input  logic                  in_rs2_rdy,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_uses_imm,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic                  wb_valid,
  input  logic [REG_AW-1:0]     wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] lhs,
  output logic [DATA_WIDTH-1:0] rhs,
  output logic                  lhs_valid,
  output logic                  rhs_valid,
  output logic                  uses_imm,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [REG_AW-1:0]     out_rd
);

  typedef struct packed {
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic [DATA_WIDTH-1:0] lhs;
    logic [DATA_WIDTH-1:0] rhs;
    logic                  lhs_v;
    logic                  rhs_v;
    logic                  uses_imm;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [REG_AW-1:0]     rd;
  } entry_t;

  localparam logic [1:0] C_EMPTY = 2'd0;
  localparam logic [1:0] C_ONE   = 2'd1;
  localparam logic [1:0] C_FULL  = 2'd2;

  entry_t     head_q, head_d, tail_q, tail_d;
  entry_t     w_new, w_head_snp, w_tail_snp;
  logic [1:0] count_q, count_d;
  logic       w_push, w_pop;
  logic       w_wb_hit1, w_wb_hit2;

  // Unresolved operands pick up a matching writeback; x0 is never a real producer.
  function automatic entry_t f_snoop(input entry_t e, input logic occ, input logic wv,
                                     input logic [REG_AW-1:0] wr,
                                     input logic [DATA_WIDTH-1:0] wd);
    entry_t r;
    r = e;
    if (occ && wv && (wr != '0)) begin
      if (!e.lhs_v && (wr == e.rs1)) begin
        r.lhs   = wd;
        r.lhs_v = 1'b1;
      end
      if (!e.rhs_v && (wr == e.rs2)) begin
        r.rhs   = wd;
        r.rhs_v = 1'b1;
      end
    end
    return r;
  endfunction

  assign in_ready  = (count_q != C_FULL);
  assign out_valid = (count_q != C_EMPTY) & head_q.lhs_v & head_q.rhs_v;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign lhs       = head_q.lhs;
  assign rhs       = head_q.rhs;
  assign lhs_valid = (count_q != C_EMPTY) & head_q.lhs_v;
  assign rhs_valid = (count_q != C_EMPTY) & head_q.rhs_v;
  assign uses_imm  = head_q.uses_imm;
  assign funct3    = head_q.funct3;
  assign funct7    = head_q.funct7;
  assign out_rd    = head_q.rd;

  assign w_wb_hit1 = wb_valid & (wb_rd == in_rs1);
  assign w_wb_hit2 = wb_valid & (wb_rd == in_rs2);

  always_comb begin
    w_new          = '0;
    w_new.rs1      = in_rs1;
    w_new.rs2      = in_rs2;
    w_new.uses_imm = in_uses_imm;
    w_new.funct3   = in_funct3;
    w_new.funct7   = in_funct7;
    w_new.rd       = in_rd;
    w_new.lhs_v    = in_rs1_rdy | (in_rs1 == '0) | w_wb_hit1;
    if (in_rs1 == '0)    w_new.lhs = '0;
    else if (in_rs1_rdy) w_new.lhs = in_rs1_data;
    else if (w_wb_hit1)  w_new.lhs = wb_data;
    if (in_uses_imm) begin
      w_new.rhs   = in_imm;
      w_new.rhs_v = 1'b1;
    end else begin
      w_new.rhs_v = in_rs2_rdy | (in_rs2 == '0) | w_wb_hit2;
      if (in_rs2 == '0)    w_new.rhs = '0;
      else if (in_rs2_rdy) w_new.rhs = in_rs2_data;
      else if (w_wb_hit2)  w_new.rhs = wb_data;
    end
  end

  assign w_head_snp = f_snoop(head_q, count_q != C_EMPTY, wb_valid, wb_rd, wb_data);
  assign w_tail_snp = f_snoop(tail_q, count_q == C_FULL, wb_valid, wb_rd, wb_data);

  always_comb begin
    head_d  = w_head_snp;
    tail_d  = w_tail_snp;
    count_d = count_q;
    if (w_pop && w_push) begin
      head_d = w_new;
    end else if (w_pop) begin
      head_d  = w_tail_snp;
      count_d = count_q - 2'd1;
    end else if (w_push) begin
      if (count_q == C_EMPTY) head_d = w_new;
      else                    tail_d = w_new;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= C_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [63:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_rs1_rdy, in_rs2_rdy, in_uses_imm;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        out_valid, out_ready;
  logic [63:0] lhs, rhs;
  logic        lhs_valid, rhs_valid, uses_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  out_rd;

  int checks = 0;
  int failures = 0;

  alu_operand_stage #(.DATA_WIDTH(64), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs1_data(in_rs1_data), .in_rs1_rdy(in_rs1_rdy),
    .in_rs2(in_rs2), .in_rs2_data(in_rs2_data), .in_rs2_rdy(in_rs2_rdy),
    .in_imm(in_imm), .in_uses_imm(in_uses_imm),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .lhs(lhs), .rhs(rhs), .lhs_valid(lhs_valid), .rhs_valid(rhs_valid),
    .uses_imm(uses_imm), .funct3(funct3), .funct7(funct7), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [4:0] rs1, input logic [63:0] d1, input logic r1,
                          input logic [4:0] rs2, input logic [63:0] d2, input logic r2,
                          input logic [63:0] imm, input logic ui,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd);
    in_valid = 1'b1;
    in_rs1 = rs1; in_rs1_data = d1; in_rs1_rdy = r1;
    in_rs2 = rs2; in_rs2_data = d2; in_rs2_rdy = r2;
    in_imm = imm; in_uses_imm = ui;
    in_funct3 = f3; in_funct7 = f7; in_rd = rd;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [63:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive_op(5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 1'b0, 3'd0, 7'd0, 5'd0);
    in_valid = 1'b0;
    wb(1'b0, 5'd0, 64'd0);
    #1;
    chk("rst_in_ready_async", in_ready, 1);
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lhs", lhs, 0);
    chk("rst_rhs", rhs, 0);
    chk("rst_flags", {lhs_valid, rhs_valid, uses_imm}, 0);
    chk("rst_out_rd", out_rd, 0);
    rst = 1'b0;
    step();

    // Basic add, both operands ready
    drive_op(5'd3, 64'd5, 1'b1, 5'd4, 64'd7, 1'b1, 64'd0, 1'b0, 3'd0, 7'd0, 5'd1);
    step(); in_valid = 1'b0;
    chk("add_out_valid", out_valid, 1);
    chk("add_lhs", lhs, 64'd5);
    chk("add_rhs", rhs, 64'd7);
    chk("add_funct", {funct3, funct7}, 0);
    chk("add_rd", out_rd, 5'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("add_drained", out_valid, 0);
    chk("empty_flags", {lhs_valid, rhs_valid}, 0);

    // Immediate op waiting on rs1 writeback
    drive_op(5'd6, 64'hDEAD, 1'b0, 5'd2, 64'd0, 1'b0, 64'h10, 1'b1, 3'd4, 7'd0, 5'd2);
    step(); in_valid = 1'b0;
    chk("imm_wait_out_valid", out_valid, 0);
    chk("imm_rhs_valid", rhs_valid, 1);
    chk("imm_lhs_valid", lhs_valid, 0);
    chk("imm_rhs", rhs, 64'h10);
    wb(1'b1, 5'd6, 64'hAA);
    step(); wb(1'b0, 5'd0, 64'd0);
    chk("snoop_lhs", lhs, 64'hAA);
    chk("snoop_out_valid", out_valid, 1);
    chk("snoop_funct3", funct3, 3'd4);
    chk("snoop_uses_imm", uses_imm, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Capture-time bypass from the writeback bus
    drive_op(5'd1, 64'h11, 1'b1, 5'd9, 64'h999, 1'b0, 64'd0, 1'b0, 3'd1, 7'h20, 5'd3);
    wb(1'b1, 5'd9, 64'h42);
    step(); in_valid = 1'b0; wb(1'b0, 5'd0, 64'd0);
    chk("bypass_rhs", rhs, 64'h42);
    chk("bypass_rhs_valid", rhs_valid, 1);
    chk("bypass_out_valid", out_valid, 1);
    chk("bypass_funct7", funct7, 7'h20);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // x0 source and x0 writeback
    drive_op(5'd0, 64'hFFFF, 1'b0, 5'd5, 64'h1234, 1'b0, 64'd0, 1'b0, 3'd0, 7'd0, 5'd4);
    step(); in_valid = 1'b0;
    chk("x0_lhs", lhs, 0);
    chk("x0_lhs_valid", lhs_valid, 1);
    chk("x0_rhs_valid", rhs_valid, 0);
    wb(1'b1, 5'd0, 64'h1);
    step();
    chk("x0_wb_lhs", lhs, 0);
    chk("x0_wb_rhs_valid", rhs_valid, 0);
    chk("x0_wb_out_valid", out_valid, 0);
    wb(1'b1, 5'd5, 64'h55);
    step(); wb(1'b0, 5'd0, 64'd0);
    chk("x0_rs2_snoop", rhs, 64'h55);
    chk("x0_rs2_out_valid", out_valid, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Blocked head holds back a resolved tail
    drive_op(5'd7, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'h3, 1'b1, 3'd0, 7'd0, 5'd5);
    step();
    drive_op(5'd8, 64'h808, 1'b1, 5'd10, 64'h1010, 1'b1, 64'd0, 1'b0, 3'd0, 7'd0, 5'd6);
    step(); in_valid = 1'b0;
    chk("order_full_in_ready", in_ready, 0);
    chk("order_head_blocked", out_valid, 0);
    out_ready = 1'b1;
    wb(1'b1, 5'd7, 64'h77);
    step(); wb(1'b0, 5'd0, 64'd0);
    chk("order_head_lhs", lhs, 64'h77);
    chk("order_head_rd", out_rd, 5'd5);
    chk("order_head_valid", out_valid, 1);
    step();
    chk("order_tail_lhs", lhs, 64'h808);
    chk("order_tail_rd", out_rd, 5'd6);
    step(); out_ready = 1'b0;
    chk("order_empty", out_valid, 0);

    // Tail snooped in the same cycle it moves to head
    drive_op(5'd1, 64'h1, 1'b1, 5'd2, 64'h2, 1'b1, 64'd0, 1'b0, 3'd0, 7'd0, 5'd7);
    step();
    drive_op(5'd11, 64'd0, 1'b0, 5'd12, 64'hC, 1'b1, 64'd0, 1'b0, 3'd0, 7'd0, 5'd8);
    step(); in_valid = 1'b0;
    out_ready = 1'b1; wb(1'b1, 5'd11, 64'h88);
    step(); out_ready = 1'b0; wb(1'b0, 5'd0, 64'd0);
    chk("move_snoop_rd", out_rd, 5'd8);
    chk("move_snoop_lhs", lhs, 64'h88);
    chk("move_snoop_valid", out_valid, 1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Backpressure: three ops, one held off, then drained in order
    drive_op(5'd1, 64'hA1, 1'b1, 5'd2, 64'hB1, 1'b1, 64'd0, 1'b0, 3'd0, 7'd0, 5'd11);
    step();
    chk("bp_ready_after_1", in_ready, 1);
    drive_op(5'd1, 64'hA2, 1'b1, 5'd2, 64'hB2, 1'b1, 64'd0, 1'b0, 3'd0, 7'd0, 5'd12);
    step();
    chk("bp_ready_after_2", in_ready, 0);
    drive_op(5'd1, 64'hA3, 1'b1, 5'd2, 64'hB3, 1'b1, 64'd0, 1'b0, 3'd0, 7'd0, 5'd13);
    step();
    chk("bp_still_full", in_ready, 0);
    chk("bp_head_op1", lhs, 64'hA1);
    out_ready = 1'b1;
    step();
    chk("bp_op2_lhs", lhs, 64'hA2);
    chk("bp_op2_valid", out_valid, 1);
    chk("bp_op2_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    chk("bp_op3_lhs", lhs, 64'hA3);
    chk("bp_op3_rhs", rhs, 64'hB3);
    chk("bp_op3_rd", out_rd, 5'd13);
    step(); out_ready = 1'b0;
    chk("bp_drained", out_valid, 0);

    // Async reset while full
    drive_op(5'd1, 64'hC1, 1'b1, 5'd2, 64'hD1, 1'b1, 64'd0, 1'b0, 3'd0, 7'd0, 5'd14);
    step(); step(); in_valid = 1'b0;
    chk("prerst_full", in_ready, 0);
    rst = 1'b1; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_lhs", lhs, 0);
    chk("midrst_rhs", rhs, 0);
    step(); rst = 1'b0; step();
    chk("postrst_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
